// File: rtl/mux_sel_rr.sv
// mux_sel_rr: registered NCH-to-1 channel selector with valid/ready handshakes.
// The selection is either fixed (external sel) or round-robin among the
// requesting channels. A single-entry output register holds the selected word,
// and a wrapping counter tracks completed output transfers.
//
// Ports:
//   clk, rst_n     rising-edge clock, synchronous active-low reset
//   mode           0 = fixed select via sel, 1 = round-robin
//   sel            channel index used in fixed mode
//   in_data        flattened channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid       per-channel valid
//   in_ready       per-channel ready (combinational)
//   out_data       registered selected word
//   out_ch         channel that supplied out_data
//   out_valid      output register holds a word
//   out_ready      downstream accepts the word
//   xfer_count     completed output handshakes, wraps modulo 2**CNTW
module mux_sel_rr #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NCH   = 4,
    parameter int unsigned SELW  = 2,
    parameter int unsigned CNTW  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mode,
    input  logic [SELW-1:0]        sel,
    input  logic [NCH*WIDTH-1:0]   in_data,
    input  logic [NCH-1:0]         in_valid,
    output logic [NCH-1:0]         in_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [SELW-1:0]        out_ch,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [CNTW-1:0]        xfer_count
);

    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic [SELW-1:0]  out_ch_q, out_ch_d;
    logic             out_valid_q, out_valid_d;
    logic [SELW-1:0]  ptr_q, ptr_d;
    logic [CNTW-1:0]  xfer_count_q, xfer_count_d;

    logic             load_en;
    logic [SELW-1:0]  gnt;
    logic             gnt_valid;
    logic             in_xfer;
    logic [WIDTH-1:0] gnt_data;

    // Grant selection: fixed index, or first requester at/after ptr with wrap.
    always_comb begin
        gnt       = '0;
        gnt_valid = 1'b0;
        if (!mode) begin
            // Indices at or above NCH never match, so an out-of-range sel gives no grant.
            for (int i = 0; i < NCH; i++) begin
                if (SELW'(i) == sel && in_valid[i]) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
        end else begin
            // First pass covers ptr..NCH-1, second pass wraps to 0..ptr-1.
            for (int i = 0; i < NCH; i++) begin
                if (!gnt_valid && in_valid[i] && SELW'(i) >= ptr_q) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
            for (int i = 0; i < NCH; i++) begin
                if (!gnt_valid && in_valid[i]) begin
                    gnt       = SELW'(i);
                    gnt_valid = 1'b1;
                end
            end
        end
    end

    // Handshake and data steering for the granted channel.
    always_comb begin
        load_en  = !out_valid_q || out_ready;
        in_xfer  = rst_n && load_en && gnt_valid;
        gnt_data = '0;
        in_ready = '0;
        for (int i = 0; i < NCH; i++) begin
            if (SELW'(i) == gnt) begin
                gnt_data    = in_data[i*WIDTH +: WIDTH];
                in_ready[i] = in_xfer;
            end
        end
    end

    // Next-state for the output register, RR pointer and transfer counter.
    always_comb begin
        out_data_d   = out_data_q;
        out_ch_d     = out_ch_q;
        out_valid_d  = out_valid_q;
        ptr_d        = ptr_q;
        xfer_count_d = xfer_count_q;

        if (out_valid_q && out_ready) begin
            out_valid_d  = 1'b0;
            xfer_count_d = xfer_count_q + CNTW'(1);
        end

        // A load in the same cycle as a drain overrides the clear of out_valid.
        if (in_xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = gnt_data;
            out_ch_d    = gnt;
            if (mode) begin
                ptr_d = (32'(gnt) == NCH - 1) ? '0 : gnt + SELW'(1);
            end
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_data_q   <= '0;
            out_ch_q     <= '0;
            out_valid_q  <= 1'b0;
            ptr_q        <= '0;
            xfer_count_q <= '0;
        end else begin
            out_data_q   <= out_data_d;
            out_ch_q     <= out_ch_d;
            out_valid_q  <= out_valid_d;
            ptr_q        <= ptr_d;
            xfer_count_q <= xfer_count_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_ch     = out_ch_q;
    assign out_valid  = out_valid_q;
    assign xfer_count = xfer_count_q;

endmodule

// File: tb/tb_mux_sel_rr.sv
// Directed testbench for mux_sel_rr: a 4-channel instance with a 4-bit
// counter and a 3-channel instance used for the out-of-range select case.
module tb_mux_sel_rr;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic         mode;
    logic [1:0]   sel;
    logic [127:0] in_data;
    logic [3:0]   in_valid;
    logic [3:0]   in_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_ch;
    logic         out_valid;
    logic         out_ready;
    logic [3:0]   xfer_count;

    logic         d3_mode;
    logic [1:0]   d3_sel;
    logic [95:0]  d3_in_data;
    logic [2:0]   d3_in_valid;
    logic [2:0]   d3_in_ready;
    logic [31:0]  d3_out_data;
    logic [1:0]   d3_out_ch;
    logic         d3_out_valid;
    logic         d3_out_ready;
    logic [15:0]  d3_xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    mux_sel_rr #(.WIDTH(32), .NCH(4), .SELW(2), .CNTW(4)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid),
        .out_ready(out_ready), .xfer_count(xfer_count)
    );

    mux_sel_rr #(.WIDTH(32), .NCH(3), .SELW(2), .CNTW(16)) dut3 (
        .clk(clk), .rst_n(rst_n), .mode(d3_mode), .sel(d3_sel),
        .in_data(d3_in_data), .in_valid(d3_in_valid), .in_ready(d3_in_ready),
        .out_data(d3_out_data), .out_ch(d3_out_ch), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready), .xfer_count(d3_xfer_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_data(input logic [31:0] c3, input logic [31:0] c2,
                            input logic [31:0] c1, input logic [31:0] c0);
        in_data = {c3, c2, c1, c0};
    endtask

    initial begin
        logic [1:0]  fx_sel [5];
        logic [31:0] fx_exp [5];
        logic [1:0]  alt    [4];
        fx_sel = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd3};
        fx_exp = '{32'd1, 32'd2, 32'd3, 32'd1, 32'd4};
        alt    = '{2'd1, 2'd3, 2'd1, 2'd3};

        rst_n = 1'b0; mode = 1'b0; sel = 2'd0; in_data = '0; in_valid = '0; out_ready = 1'b0;
        d3_mode = 1'b0; d3_sel = 2'd0; d3_in_data = '0; d3_in_valid = '0; d3_out_ready = 1'b0;

        // Reset state
        tick();
        tick();
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        chk("rst_out_ch", 64'(out_ch), 64'd0);
        chk("rst_xfer", 64'(xfer_count), 64'd0);
        set_data(32'd4, 32'd3, 32'd2, 32'd1);
        in_valid = 4'hF; out_ready = 1'b1;
        #1;
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        rst_n = 1'b1;

        // Fixed-mode sweep
        for (int k = 0; k < 5; k++) begin
            sel = fx_sel[k];
            #1;
            chk("fix_in_ready", 64'(in_ready), 64'(4'b0001 << fx_sel[k]));
            tick();
            chk("fix_out_data", 64'(out_data), 64'(fx_exp[k]));
            chk("fix_out_ch", 64'(out_ch), 64'(fx_sel[k]));
            chk("fix_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid = 4'h0;
        tick();
        chk("fix_drain_valid", 64'(out_valid), 64'd0);
        chk("fix_drain_data", 64'(out_data), 64'd4);
        chk("fix_xfer", 64'(xfer_count), 64'd5);

        // Round-robin over all four channels (ptr still 0 after fixed mode)
        mode = 1'b1; in_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("rr_in_ready", 64'(in_ready), 64'(4'b0001 << (k % 4)));
            tick();
            chk("rr_out_ch", 64'(out_ch), 64'(k % 4));
            chk("rr_out_data", 64'(out_data), 64'((k % 4) + 1));
        end
        // ptr is back at 0, so channels 1 and 3 alternate starting with 1
        in_valid = 4'b1010;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_alt_ch", 64'(out_ch), 64'(alt[k]));
        end
        in_valid = 4'h0;
        tick();
        chk("rr_drain_valid", 64'(out_valid), 64'd0);
        chk("rr_xfer_wrap", 64'(xfer_count), 64'd1);

        // Backpressure: word 100 from channel 3, then stall for 3 cycles
        set_data(32'd100, 32'd3, 32'd2, 32'd55);
        in_valid = 4'b1000;
        #1;
        chk("bp_in_ready_load", 64'(in_ready), 64'b1000);
        tick();
        chk("bp_load_data", 64'(out_data), 64'd100);
        chk("bp_load_ch", 64'(out_ch), 64'd3);
        out_ready = 1'b0; in_valid = 4'hF;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("bp_in_ready_stall", 64'(in_ready), 64'd0);
            tick();
            chk("bp_data_hold", 64'(out_data), 64'd100);
            chk("bp_valid_hold", 64'(out_valid), 64'd1);
            chk("bp_xfer_hold", 64'(xfer_count), 64'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_release", 64'(in_ready), 64'b0001);
        tick();
        chk("bp_next_data", 64'(out_data), 64'd55);
        chk("bp_next_ch", 64'(out_ch), 64'd0);
        chk("bp_xfer_once", 64'(xfer_count), 64'd2);

        // Build out_valid=1, out_data=3, xfer=7, ptr=2, then reset
        set_data(32'd4, 32'd3, 32'd2, 32'd1);
        in_valid = 4'b0010;
        tick();
        chk("pre_rst_ch1", 64'(out_ch), 64'd1);
        mode = 1'b0; sel = 2'd2; in_valid = 4'hF;
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_data", 64'(out_data), 64'd3);
        chk("pre_rst_xfer", 64'(xfer_count), 64'd7);
        rst_n = 1'b0; mode = 1'b1;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        tick();
        chk("mid_rst_valid", 64'(out_valid), 64'd0);
        chk("mid_rst_data", 64'(out_data), 64'd0);
        chk("mid_rst_ch", 64'(out_ch), 64'd0);
        chk("mid_rst_xfer", 64'(xfer_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'b0001);
        tick();
        chk("post_rst_ch", 64'(out_ch), 64'd0);
        chk("post_rst_data", 64'(out_data), 64'd1);

        // Counter wrap with a 4-bit counter: 18 back-to-back loads after reset
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 18; k++) begin
            tick();
            chk("wrap_xfer", 64'(xfer_count), 64'((k - 1) % 16));
            chk("wrap_ch", 64'(out_ch), 64'((k - 1) % 4));
        end

        // Three-channel instance: sel=2 is the last valid index, sel=3 never grants
        in_valid = 4'h0;
        d3_in_data = {32'd30, 32'd20, 32'd10};
        d3_in_valid = 3'b111; d3_sel = 2'd2; d3_out_ready = 1'b0;
        #1;
        chk("d3_in_ready_sel2", 64'(d3_in_ready), 64'b100);
        tick();
        chk("d3_data_sel2", 64'(d3_out_data), 64'd30);
        chk("d3_ch_sel2", 64'(d3_out_ch), 64'd2);
        d3_sel = 2'd3; d3_out_ready = 1'b1;
        #1;
        chk("d3_in_ready_sel3", 64'(d3_in_ready), 64'd0);
        tick();
        chk("d3_drain_valid", 64'(d3_out_valid), 64'd0);
        chk("d3_drain_data", 64'(d3_out_data), 64'd30);
        chk("d3_in_ready_idle", 64'(d3_in_ready), 64'd0);
        tick();
        chk("d3_idle_valid", 64'(d3_out_valid), 64'd0);
        chk("d3_xfer", 64'(d3_xfer_count), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mux_sel_rr.md
Name: mux_sel_rr

Overview:
- Parametrised, registered N-channel selector for the datapath. Successor to the fixed 4:1 32-bit combinational mux.
- Routes one of NCH input channels into a single output register using valid/ready handshakes on every channel.
- Two selection modes: fixed (external sel, as in the older mux) and round-robin arbitration among requesting channels.
- Counts completed output transfers for lab-level performance checks.

Parameters:
- WIDTH, 32, data width per channel.
- NCH, 4, number of input channels (2..16).
- SELW, 2, width of sel/out_ch; must satisfy 2**SELW >= NCH.
- CNTW, 16, width of transfer counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on the rising edge of clk.
- mode  input  1  0 = fixed select, 1 = round-robin.
- sel  input  SELW  channel index used in fixed mode.
- in_data  input  NCH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready; combinational from state and inputs.
- out_data  output  WIDTH  registered selected data.
- out_ch  output  SELW  index of the channel that supplied out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  downstream accepts the word.
- xfer_count  output  CNTW  number of completed output handshakes (out_valid && out_ready).

Behaviour:
- Reset: when rst_n = 0 at a clk edge, the following clear together: out_valid = 0, out_data = 0, out_ch = 0, RR pointer ptr = 0, xfer_count = 0. Reset mid-transfer discards the held word. in_ready is all zero while rst_n = 0.
- Load enable: load_en = !out_valid || out_ready. The output register is a single entry with no skid buffer.
- Grant (combinational, at most one channel per cycle):
  - Fixed mode: gnt = sel, valid only if sel < NCH and in_valid[sel] = 1. If sel >= NCH, there is never a grant.
  - RR mode: gnt = the first i with in_valid[i] = 1, searching ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (modulo NCH).
- Handshake signals:
  - in_ready[i] = rst_n && load_en && grant_valid && (i == gnt).
  - The upstream transfer completes on in_valid[i] && in_ready[i].
- On an input transfer: out_data <= in_data[gnt], out_ch <= gnt, out_valid <= 1.
- In RR mode only, on an input transfer: ptr <= (gnt + 1) mod NCH. In fixed mode ptr holds its value.
- Drain without refill: if out_valid && out_ready and there is no input transfer, then out_valid <= 0. out_data and out_ch hold their last values.
- Simultaneous drain and load: the new word replaces the old one in the same cycle, giving throughput of 1 word/cycle.
- Stall: while out_valid && !out_ready, out_data, out_ch and out_valid are held stable and all in_ready = 0.
- Latency: an accepted word appears on out_data with out_valid = 1 one cycle after its handshake.
- Mode/sel changes: mode and sel are sampled every cycle and affect only the next grant, never the held word. Switching fixed -> RR resumes from the retained ptr.
- Counter: xfer_count increments by 1 on each out_valid && out_ready and wraps modulo 2**CNTW without saturating.
- No grant: if no channel is eligible, no state changes except drain.

Test Plan:
- Fixed-mode sweep: in_data channels = 1, 2, 3, 4, all valid, out_ready = 1, sel stepped 0 -> 1 -> 2 -> 0 -> 3 at 1 cycle each. Expect out_data = 1, 2, 3, 1, 4, each one cycle after its sel, with out_ch matching sel, and xfer_count = 5 after the last word drains.
- Round-robin fairness: mode = 1, all four channels valid continuously, out_ready = 1. Expect out_ch sequence 0, 1, 2, 3, 0, 1 and in_ready one-hot rotating each cycle. Then in_valid = 4'b1010 -> out_ch alternates 1, 3, 1, 3.
- Backpressure: a word of 100 is held on channel 3, then out_ready = 0 for 3 cycles. Expect out_data = 100 stable, out_valid = 1, in_ready = 0 for all channels, xfer_count unchanged. Release out_ready -> exactly one count increment and the next word loads in the same cycle.
- Invalid select: NCH = 3, SELW = 2, sel = 3, fixed mode, all channels valid. Expect no grant, in_ready = 0, out_valid falls to 0 after the pending word drains.
- Reset mid-operation: out_valid = 1, out_data = 32'd3, xfer_count = 7, ptr = 2, then rst_n = 0 for 1 cycle. Expect at the next edge out_valid = 0, out_data = 0, out_ch = 0, xfer_count = 0, and the next RR grant comes from channel 0.
- Counter wrap: CNTW = 4, 17 back-to-back transfers. Expect xfer_count sequence ending 15 -> 0 -> 1.
